// File: rtl/bram_pkg.sv
// Shared constants and types for the BRAM port responder and its read pipelines.
package bram_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DEPTH    = 1024;
  localparam int DEF_READ_LAT = 2;
  localparam int DEF_BYTES    = DEF_DATA_W / 8;

  // One port's request as seen by the array, at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] din;
    logic                  en;
    logic [DEF_BYTES-1:0]  we;
  } bram_req_t;

  // One stage of a read-return pipeline, at the default data width.
  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] data;
    logic                  oor;
  } rd_pipe_t;

endpackage

// File: rtl/bram_rd_pipe.sv
// Fixed-latency read-return pipeline for one BRAM port.
// Carries {valid, data, oor}; dout holds the last delivered word between responses.
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_oor,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_oor
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              oor;
  } stage_t;

  stage_t            stages [READ_LAT];
  logic [DATA_W-1:0] held;

  // The last stage doubles as the output register; held keeps the previous response.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int i = 0; i < READ_LAT; i++) begin
        stages[i] <= '0;
      end
      held <= '0;
    end else begin
      stages[0] <= '{valid: in_valid, data: in_data, oor: in_oor};
      for (int i = 1; i < READ_LAT; i++) begin
        stages[i] <= stages[i-1];
      end
      if (stages[READ_LAT-1].valid) begin
        held <= stages[READ_LAT-1].data;
      end
    end
  end

  assign dout_valid = stages[READ_LAT-1].valid;
  assign dout_oor   = stages[READ_LAT-1].valid & stages[READ_LAT-1].oor;
  assign dout       = stages[READ_LAT-1].valid ? stages[READ_LAT-1].data : held;

endmodule

// File: rtl/bram_port_responder.sv
// Dual-port word-addressed block RAM: port A for the host/loader, port B for the data-fetch unit.
// Byte-enabled writes, read-first across ports, port B wins same-word byte conflicts.
module bram_port_responder
  import bram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter     INIT_FILE = ""
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  input  logic                ena,
  input  logic [DATA_W/8-1:0] wea,
  output logic [DATA_W-1:0]   douta,
  output logic                douta_valid,
  input  logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   dinb,
  input  logic                enb,
  input  logic [DATA_W/8-1:0] web,
  output logic [DATA_W-1:0]   doutb,
  output logic                doutb_valid,
  output logic                oorb,
  output logic                collision
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_in_range, b_in_range;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic              a_rd, a_wr, b_rd, b_wr;
  logic [DATA_W-1:0] a_rd_data, b_rd_data;
  logic              dual_write_hit;
  logic              a_oor_unused;

  // Range test looks at every address bit so high addresses never alias onto low words.
  always_comb begin
    a_in_range     = ~|(addra >> IDX_W);
    b_in_range     = ~|(addrb >> IDX_W);
    a_idx          = addra[IDX_W-1:0];
    b_idx          = addrb[IDX_W-1:0];
    a_rd           = RSTN & ena & ~|wea;
    b_rd           = RSTN & enb & ~|web;
    a_wr           = RSTN & ena & (|wea) & a_in_range;
    b_wr           = RSTN & enb & (|web) & b_in_range;
    a_rd_data      = a_in_range ? mem[a_idx] : '0;
    b_rd_data      = b_in_range ? mem[b_idx] : '0;
    dual_write_hit = a_wr & b_wr & (a_idx == b_idx);
  end

  // Port B's byte update is issued after port A's, so B owns any byte both ports enable.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < BYTES; i++) begin
      if (a_wr && wea[i]) begin
        mem[a_idx][8*i +: 8] <= dina[8*i +: 8];
      end
      if (b_wr && web[i]) begin
        mem[b_idx][8*i +: 8] <= dinb[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      collision <= 1'b0;
    end else begin
      collision <= dual_write_hit;
    end
  end

  bram_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_pipe_a (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .in_valid   (a_rd),
    .in_data    (a_rd_data),
    .in_oor     (~a_in_range),
    .dout       (douta),
    .dout_valid (douta_valid),
    .dout_oor   (a_oor_unused)
  );

  bram_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_pipe_b (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .in_valid   (b_rd),
    .in_data    (b_rd_data),
    .in_oor     (~b_in_range),
    .dout       (doutb),
    .dout_valid (doutb_valid),
    .dout_oor   (oorb)
  );

endmodule

// File: tb/tb_bram_port_responder.sv
// Directed bench for bram_port_responder: latency, burst, byte enables, collision, range, reset.
module tb_bram_port_responder;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic [ADDR_W-1:0] addra = '0;
  logic [DATA_W-1:0] dina = '0;
  logic              ena = 1'b0;
  logic [3:0]        wea = '0;
  logic [DATA_W-1:0] douta;
  logic              douta_valid;
  logic [ADDR_W-1:0] addrb = '0;
  logic [DATA_W-1:0] dinb = '0;
  logic              enb = 1'b0;
  logic [3:0]        web = '0;
  logic [DATA_W-1:0] doutb;
  logic              doutb_valid;
  logic              oorb;
  logic              collision;

  int checks = 0;
  int passes = 0;

  always #5 CLK = ~CLK;

  bram_port_responder #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .READ_LAT  (2),
    .INIT_FILE ("")
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .addra       (addra),
    .dina        (dina),
    .ena         (ena),
    .wea         (wea),
    .douta       (douta),
    .douta_valid (douta_valid),
    .addrb       (addrb),
    .dinb        (dinb),
    .enb         (enb),
    .web         (web),
    .doutb       (doutb),
    .doutb_valid (doutb_valid),
    .oorb        (oorb),
    .collision   (collision)
  );

  // Single-cycle request drivers; each returns at the next falling edge with the port idle.
  task automatic wr_a(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    addra = addr; dina = data; wea = we; ena = 1'b1;
    @(negedge CLK);
    ena = 1'b0; wea = '0;
  endtask

  task automatic wr_b(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    addrb = addr; dinb = data; web = we; enb = 1'b1;
    @(negedge CLK);
    enb = 1'b0; web = '0;
  endtask

  task automatic rd_b(input logic [31:0] addr);
    addrb = addr; web = '0; enb = 1'b1;
    @(negedge CLK);
    enb = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    ena = 1'b1; addra = 32'd3; enb = 1'b1; addrb = 32'd4;
    repeat (3) @(negedge CLK);
    checks++;
    if ({douta_valid, doutb_valid, oorb, collision} !== 4'b0000) begin
      $display("[TB] FAIL reset_flags: got %b expected 0000", {douta_valid, doutb_valid, oorb, collision});
    end else passes++;
    checks++;
    if ({douta, doutb} !== 64'h0) begin
      $display("[TB] FAIL reset_data: got douta=%h doutb=%h expected 0/0", douta, doutb);
    end else passes++;
    RSTN = 1'b1; ena = 1'b0; enb = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({douta_valid, doutb_valid} !== 2'b00) begin
      $display("[TB] FAIL reset_dropped_reqs: got %b expected 00", {douta_valid, doutb_valid});
    end else passes++;
  endtask

  task automatic test_latency();
    wr_a(32'd5, 32'hDEADBEEF, 4'hF);
    rd_b(32'd5);
    checks++;
    if (doutb_valid !== 1'b0) begin
      $display("[TB] FAIL latency_early: got valid=%b expected 0", doutb_valid);
    end else passes++;
    @(negedge CLK);
    checks++;
    if ({doutb_valid, doutb} !== {1'b1, 32'hDEADBEEF}) begin
      $display("[TB] FAIL latency_data: got valid=%b data=%h expected 1/deadbeef", doutb_valid, doutb);
    end else passes++;
    checks++;
    if (douta_valid !== 1'b0) begin
      $display("[TB] FAIL write_no_resp_a: got valid=%b expected 0", douta_valid);
    end else passes++;
    @(negedge CLK);
    checks++;
    if ({doutb_valid, doutb} !== {1'b0, 32'hDEADBEEF}) begin
      $display("[TB] FAIL latency_single_hold: got valid=%b data=%h expected 0/deadbeef", doutb_valid, doutb);
    end else passes++;
  endtask

  task automatic test_burst();
    for (int i = 0; i < 16; i++) wr_a(32'(i), 32'(i * 3), 4'hF);
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 19; i++) begin
      logic [31:0] expv;
      expv = 32'((i - 2) * 3);
      if (i >= 2 && i < 18) begin
        checks++;
        if ({doutb_valid, doutb} !== {1'b1, expv}) begin
          $display("[TB] FAIL burst_beat%0d: got valid=%b data=%h expected 1/%h", i - 2, doutb_valid, doutb, expv);
        end else passes++;
      end else begin
        checks++;
        if (doutb_valid !== 1'b0) begin
          $display("[TB] FAIL burst_edge%0d: got valid=%b expected 0", i, doutb_valid);
        end else passes++;
      end
      if (i < 16) begin
        addrb = 32'(i); web = '0; enb = 1'b1;
      end else begin
        enb = 1'b0;
      end
      @(negedge CLK);
    end
    wr_a(32'd5, 32'hDEADBEEF, 4'hF);
    wr_a(32'd0, 32'h13579BDF, 4'hF);
  endtask

  task automatic test_byte_enables();
    wr_a(32'd7, 32'h11223344, 4'hF);
    wr_b(32'd7, 32'hAABBCCDD, 4'b0101);
    addrb = 32'd7; dinb = 32'hFFFFFFFF; web = 4'hF; enb = 1'b0;
    @(negedge CLK);
    web = '0;
    checks++;
    if (doutb_valid !== 1'b0) begin
      $display("[TB] FAIL write_no_resp_b: got valid=%b expected 0", doutb_valid);
    end else passes++;
    rd_b(32'd7);
    @(negedge CLK);
    checks++;
    if ({doutb_valid, doutb} !== {1'b1, 32'h11BB33DD}) begin
      $display("[TB] FAIL byte_merge: got valid=%b data=%h expected 1/11bb33dd", doutb_valid, doutb);
    end else passes++;
  endtask

  task automatic test_collision();
    checks++;
    if (collision !== 1'b0) begin
      $display("[TB] FAIL collision_idle: got %b expected 0", collision);
    end else passes++;
    addra = 32'd9; dina = 32'h0000FFFF; wea = 4'hF; ena = 1'b1;
    addrb = 32'd9; dinb = 32'hABCD0000; web = 4'b1100; enb = 1'b1;
    @(negedge CLK);
    ena = 1'b0; wea = '0; enb = 1'b0; web = '0;
    checks++;
    if (collision !== 1'b1) begin
      $display("[TB] FAIL collision_pulse: got %b expected 1", collision);
    end else passes++;
    @(negedge CLK);
    checks++;
    if (collision !== 1'b0) begin
      $display("[TB] FAIL collision_once: got %b expected 0", collision);
    end else passes++;
    addra = 32'd9; wea = '0; ena = 1'b1;
    @(negedge CLK);
    ena = 1'b0;
    @(negedge CLK);
    checks++;
    if ({douta_valid, douta} !== {1'b1, 32'hABCDFFFF}) begin
      $display("[TB] FAIL collision_merge: got valid=%b data=%h expected 1/abcdffff", douta_valid, douta);
    end else passes++;
    addra = 32'd10; dina = 32'h1; wea = 4'hF; ena = 1'b1;
    addrb = 32'd11; dinb = 32'h2; web = 4'hF; enb = 1'b1;
    @(negedge CLK);
    ena = 1'b0; wea = '0; enb = 1'b0; web = '0;
    checks++;
    if (collision !== 1'b0) begin
      $display("[TB] FAIL collision_diff_word: got %b expected 0", collision);
    end else passes++;
    addra = 32'd9; dina = 32'h12345678; wea = 4'hF; ena = 1'b1;
    addrb = 32'd9; web = '0; enb = 1'b1;
    @(negedge CLK);
    ena = 1'b0; wea = '0; enb = 1'b0;
    @(negedge CLK);
    checks++;
    if ({doutb_valid, doutb} !== {1'b1, 32'hABCDFFFF}) begin
      $display("[TB] FAIL read_first: got valid=%b data=%h expected 1/abcdffff", doutb_valid, doutb);
    end else passes++;
  endtask

  task automatic test_out_of_range();
    rd_b(32'd1024);
    checks++;
    if (oorb !== 1'b0) begin
      $display("[TB] FAIL oor_early: got %b expected 0", oorb);
    end else passes++;
    @(negedge CLK);
    checks++;
    if ({doutb_valid, oorb, doutb} !== {1'b1, 1'b1, 32'h0}) begin
      $display("[TB] FAIL oor_read: got valid=%b oor=%b data=%h expected 1/1/0", doutb_valid, oorb, doutb);
    end else passes++;
    @(negedge CLK);
    checks++;
    if ({doutb_valid, oorb} !== 2'b00) begin
      $display("[TB] FAIL oor_single: got valid=%b oor=%b expected 0/0", doutb_valid, oorb);
    end else passes++;
    rd_b(32'h0001_0005);
    @(negedge CLK);
    checks++;
    if ({doutb_valid, oorb, doutb} !== {1'b1, 1'b1, 32'h0}) begin
      $display("[TB] FAIL oor_no_wrap: got valid=%b oor=%b data=%h expected 1/1/0", doutb_valid, oorb, doutb);
    end else passes++;
    wr_b(32'd1024, 32'hCAFEF00D, 4'hF);
    rd_b(32'd0);
    @(negedge CLK);
    checks++;
    if ({doutb_valid, oorb, doutb} !== {1'b1, 1'b0, 32'h13579BDF}) begin
      $display("[TB] FAIL oor_write_dropped: got valid=%b oor=%b data=%h expected 1/0/13579bdf", doutb_valid, oorb, doutb);
    end else passes++;
    addra = 32'h0000_0405; wea = '0; ena = 1'b1;
    @(negedge CLK);
    ena = 1'b0;
    @(negedge CLK);
    checks++;
    if ({douta_valid, douta} !== {1'b1, 32'h0}) begin
      $display("[TB] FAIL oor_read_a: got valid=%b data=%h expected 1/0", douta_valid, douta);
    end else passes++;
  endtask

  task automatic test_reset_mid();
    rd_b(32'd5);
    @(negedge CLK);
    checks++;
    if ({doutb_valid, doutb} !== {1'b1, 32'hDEADBEEF}) begin
      $display("[TB] FAIL pre_reset_read: got valid=%b data=%h expected 1/deadbeef", doutb_valid, doutb);
    end else passes++;
    @(negedge CLK);
    addrb = 32'd5; web = '0; enb = 1'b1;
    @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1; enb = 1'b0;
    checks++;
    if ({doutb_valid, oorb, doutb} !== {1'b0, 1'b0, 32'h0}) begin
      $display("[TB] FAIL reset_mid_clear: got valid=%b oor=%b data=%h expected 0/0/0", doutb_valid, oorb, doutb);
    end else passes++;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (doutb_valid !== 1'b0) begin
        $display("[TB] FAIL reset_mid_no_pulse%0d: got valid=%b expected 0", i, doutb_valid);
      end else passes++;
    end
    rd_b(32'd5);
    checks++;
    if (doutb_valid !== 1'b0) begin
      $display("[TB] FAIL post_reset_early: got valid=%b expected 0", doutb_valid);
    end else passes++;
    @(negedge CLK);
    checks++;
    if ({doutb_valid, doutb} !== {1'b1, 32'hDEADBEEF}) begin
      $display("[TB] FAIL post_reset_read: got valid=%b data=%h expected 1/deadbeef", doutb_valid, doutb);
    end else passes++;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_latency();
    test_burst();
    test_byte_enables();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
